rat_timer_intr: RTL and testbench



---
 rtl/rat_timer_intr.sv | 123 ++++++++++++
 tb/tb_rat_timer_intr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rat_timer_intr.sv
// Programmable 16-bit interval timer for the RAT MCU I/O bus with a fixed-length interrupt pulse.
// Define RAT_TIMER_OVF_EN to implement the OVF status flag (STAT[1]); otherwise it reads 0.
module rat_timer_intr #(
    parameter logic [7:0] CTRL_ID   = 8'h30,
    parameter logic [7:0] TCLO_ID   = 8'h31,
    parameter logic [7:0] TCHI_ID   = 8'h32,
    parameter logic [7:0] STAT_ID   = 8'h33,
    parameter logic [7:0] CNTLO_ID  = 8'h34,
    parameter logic [7:0] CNTHI_ID  = 8'h35,
    parameter int         INT_PULSE = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] TMR_DOUT,
    output logic       TMR_SEL,
    output logic       INTERUPT
);

    logic        ctrl_en;
    logic [2:0]  ctrl_ps;
    logic [15:0] tc;
    logic [6:0]  prescaler;
    logic [6:0]  ps_mask;
    logic [15:0] count;
    logic        pend;
    logic        ovf;
    logic [3:0]  pulse_cnt;
    logic        wr_ctrl, wr_tclo, wr_tchi, wr_stat;
    logic        tick, expiry;

    assign wr_ctrl = IO_STRB && (PORT_ID == CTRL_ID);
    assign wr_tclo = IO_STRB && (PORT_ID == TCLO_ID);
    assign wr_tchi = IO_STRB && (PORT_ID == TCHI_ID);
    assign wr_stat = IO_STRB && (PORT_ID == STAT_ID);

    // Divide-by-2^PS terminal value: PS=0 gives 0, PS=7 gives 127.
    assign ps_mask = 7'h7f >> (3'd7 - ctrl_ps);
    assign tick    = ctrl_en && (prescaler == ps_mask);
    assign expiry  = tick && (count >= tc);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_en <= 1'b0;
            ctrl_ps <= 3'd0;
            tc      <= 16'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en <= OUT_PORT[0];
                ctrl_ps <= OUT_PORT[3:1];
            end
            if (wr_tclo) tc[7:0]  <= OUT_PORT;
            if (wr_tchi) tc[15:8] <= OUT_PORT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || wr_ctrl)
            prescaler <= 7'd0;
        else if (ctrl_en)
            prescaler <= tick ? 7'd0 : prescaler + 7'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET || (wr_ctrl && !OUT_PORT[0]))
            count <= 16'd0;
        else if (tick)
            count <= expiry ? 16'd0 : count + 16'd1;
    end

    // An expiry always wins over a coincident PEND clear.
    always_ff @(posedge CLK) begin
        if (RESET)
            pend <= 1'b0;
        else if (expiry)
            pend <= 1'b1;
        else if (wr_stat && OUT_PORT[0])
            pend <= 1'b0;
    end

`ifdef RAT_TIMER_OVF_EN
    // A clear landing on an expiry edge leaves OVF exactly as it was.
    always_ff @(posedge CLK) begin
        if (RESET)
            ovf <= 1'b0;
        else if (expiry && !(wr_stat && (OUT_PORT[1:0] != 2'b00)))
            ovf <= ovf | pend;
        else if (wr_stat && OUT_PORT[1] && !expiry)
            ovf <= 1'b0;
    end
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET)
            pulse_cnt <= 4'd0;
        else if (expiry)
            pulse_cnt <= 4'(INT_PULSE);
        else if (pulse_cnt != 4'd0)
            pulse_cnt <= pulse_cnt - 4'd1;
    end

    assign INTERUPT = (pulse_cnt != 4'd0);

    always_comb begin
        TMR_DOUT = 8'h00;
        TMR_SEL  = 1'b0;
        if (PORT_ID == STAT_ID) begin
            TMR_DOUT = {6'd0, ovf, pend};
            TMR_SEL  = 1'b1;
        end else if (PORT_ID == CNTLO_ID) begin
            TMR_DOUT = count[7:0];
            TMR_SEL  = 1'b1;
        end else if (PORT_ID == CNTHI_ID) begin
            TMR_DOUT = count[15:8];
            TMR_SEL  = 1'b1;
        end
    end

endmodule

// File: tb/tb_rat_timer_intr.sv
// Directed bench for rat_timer_intr: reset, period, prescale, W1C/overflow, TC shrink, retrigger, disable, reset.
module tb_rat_timer_intr;

`ifdef RAT_TIMER_OVF_EN
    localparam logic [7:0] STAT_BOTH = 8'h03;
`else
    localparam logic [7:0] STAT_BOTH = 8'h01;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] TMR_DOUT;
    logic       TMR_SEL;
    logic       INTERUPT;

    int checks = 0;
    int errors = 0;

    rat_timer_intr dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .TMR_DOUT (TMR_DOUT),
        .TMR_SEL  (TMR_SEL),
        .INTERUPT (INTERUPT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] data);
        PORT_ID  = id;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        @(posedge CLK);
        #2;
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
    endtask

    task automatic rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
        PORT_ID = id;
        #1;
        chk(tag, TMR_DOUT, exp);
    endtask

    task automatic irq(input string tag, input logic exp);
        chk(tag, {7'd0, INTERUPT}, {7'd0, exp});
    endtask

    initial begin
        RESET    = 1'b1;
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
        step(2);
        RESET = 1'b0;

        // Reset and idle read mux
        irq("rst_irq", 1'b0);
        rd("rst_stat", 8'h33, 8'h00);
        chk("rst_sel_stat", {7'd0, TMR_SEL}, 8'h01);
        rd("rst_cnthi", 8'h35, 8'h00);
        chk("rst_sel_cnthi", {7'd0, TMR_SEL}, 8'h01);
        rd("rst_nomatch", 8'h50, 8'h00);
        chk("rst_sel_nomatch", {7'd0, TMR_SEL}, 8'h00);
        PORT_ID = 8'h30;
        #1;
        chk("sel_write_id", {7'd0, TMR_SEL}, 8'h00);

        // Basic period TC=4, PS=0; CTRL write edge is edge 0
        wr(8'h31, 8'd4);
        wr(8'h32, 8'd0);
        wr(8'h30, 8'h01);
        rd("bp_cnt_e0", 8'h34, 8'd0);
        irq("bp_irq_e0", 1'b0);
        step(4);
        rd("bp_cnt_e4", 8'h34, 8'd4);
        rd("bp_stat_e4", 8'h33, 8'h00);
        irq("bp_irq_e4", 1'b0);
        step(1);
        irq("bp_irq_e5", 1'b1);
        rd("bp_cnt_e5", 8'h34, 8'd0);
        rd("bp_stat_e5", 8'h33, 8'h01);
        step(3);
        irq("bp_irq_e8", 1'b1);
        step(1);
        irq("bp_irq_e9", 1'b0);
        step(1);
        irq("bp_irq_e10", 1'b1);
        rd("ovf_stat_e10", 8'h33, STAT_BOTH);

        // W1C at edge 11, then a clear coinciding with the expiry at edge 15
        wr(8'h33, 8'h03);
        rd("w1c_stat", 8'h33, 8'h00);
        step(3);
        wr(8'h33, 8'h03);
        rd("clr_vs_exp_stat", 8'h33, 8'h01);
        rd("clr_vs_exp_cnt", 8'h34, 8'd0);
        irq("clr_vs_exp_irq", 1'b1);

        // Disable mid-operation at edge 16
        wr(8'h30, 8'h00);
        rd("dis_cnt", 8'h34, 8'd0);
        step(5);
        irq("dis_irq_quiet", 1'b0);
        rd("dis_cnt_hold", 8'h34, 8'd0);
        rd("dis_stat_hold", 8'h33, 8'h01);
        wr(8'h33, 8'h01);
        rd("dis_stat_clr", 8'h33, 8'h00);

        // Prescale TC=2, PS=2; CTRL write edge is P
        wr(8'h31, 8'd2);
        wr(8'h30, 8'h05);
        step(3);
        rd("ps_cnt_p3", 8'h34, 8'd0);
        step(1);
        rd("ps_cnt_p4", 8'h34, 8'd1);
        step(3);
        rd("ps_cnt_p7", 8'h34, 8'd1);
        step(1);
        rd("ps_cnt_p8", 8'h34, 8'd2);
        step(3);
        irq("ps_irq_p11", 1'b0);
        rd("ps_stat_p11", 8'h33, 8'h00);
        step(1);
        irq("ps_irq_p12", 1'b1);
        rd("ps_cnt_p12", 8'h34, 8'd0);
        rd("ps_stat_p12", 8'h33, 8'h01);
        step(11);
        irq("ps_irq_p23", 1'b0);
        step(1);
        irq("ps_irq_p24", 1'b1);
        rd("ps_stat_p24", 8'h33, STAT_BOTH);

        // Shrink TC from 20 to 5 at count 10
        wr(8'h30, 8'h00);
        wr(8'h33, 8'h03);
        wr(8'h31, 8'd20);
        wr(8'h30, 8'h01);
        step(10);
        rd("shr_cnt10", 8'h34, 8'd10);
        wr(8'h31, 8'd5);
        rd("shr_cnt_wr", 8'h34, 8'd11);
        rd("shr_stat_wr", 8'h33, 8'h00);
        step(1);
        irq("shr_irq", 1'b1);
        rd("shr_cnt_exp", 8'h34, 8'd0);
        rd("shr_stat_exp", 8'h33, 8'h01);

        // Retrigger with TC=0, PS=0
        wr(8'h31, 8'd0);
        for (int i = 0; i < 6; i++) begin
            irq($sformatf("retrig_irq_%0d", i), 1'b1);
            step(1);
        end
        rd("retrig_cnt", 8'h34, 8'd0);
        rd("retrig_stat", 8'h33, STAT_BOTH);

        // Reset during an active pulse
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        irq("rst_mid_irq", 1'b0);
        rd("rst_mid_stat", 8'h33, 8'h00);
        rd("rst_mid_cnt", 8'h34, 8'd0);
        step(3);
        irq("rst_mid_disabled", 1'b0);
        rd("rst_mid_cnt_hold", 8'h34, 8'd0);
        wr(8'h30, 8'h01);
        irq("rst_tc0_pre", 1'b0);
        step(1);
        irq("rst_tc0_exp", 1'b1);
        rd("rst_tc0_stat", 8'h33, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
